// File: rtl/dm_arbiter.sv
// dm_arbiter: two-port (CPU, DMA) arbiter in front of a single-port data-memory block RAM.
// Latency: grant is combinational in the request cycle; read data returns one cycle after the grant.
// Backpressure: a requester holds req and fields until gnt=1. The CPU wins contested cycles until
//   the DMA has lost STARVE_MAX cycles in a row.
// Ports: clk, sys_rstn (sync, active-low); CPU c_* and DMA d_* request/response ports;
//   dm_addr/dm_wdata/dm_byteen to the RAM, and dm_rdata back from it.
// Build option: define DM_ARB_ROUND_ROBIN_EN for alternating priority on contested cycles.
//   In that build the starvation counter is tied to 0.
module dm_arbiter #(
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic        clk,
  input  logic        sys_rstn,
  input  logic        c_req,
  input  logic        c_we,
  input  logic [31:0] c_addr,
  input  logic [31:0] c_wdata,
  input  logic [3:0]  c_byteen,
  output logic        c_gnt,
  output logic        c_rvalid,
  output logic [31:0] c_rdata,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  input  logic [3:0]  d_byteen,
  output logic        d_gnt,
  output logic        d_rvalid,
  output logic [31:0] d_rdata,
  output logic [11:0] dm_addr,
  output logic [31:0] dm_wdata,
  output logic [3:0]  dm_byteen,
  input  logic [31:0] dm_rdata
);

  typedef enum logic {PRI_CPU = 1'b0, PRI_DMA = 1'b1} pri_e;

  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

  pri_e        ptr_q, ptr_d;
  logic [3:0]  starve_cnt_q, starve_cnt_d;
  logic        rd_c_q, rd_c_d;
  logic        rd_d_q, rd_d_d;
  logic [11:0] dm_addr_q, dm_addr_d;
  logic [31:0] dm_wdata_q, dm_wdata_d;

  // Arbitration and starvation tracking.
  always_comb begin
    c_gnt        = 1'b0;
    d_gnt        = 1'b0;
    ptr_d        = ptr_q;
    starve_cnt_d = starve_cnt_q;
    if (sys_rstn) begin
      if (c_req && !d_req) begin
        c_gnt = 1'b1;
      end else if (d_req && !c_req) begin
        d_gnt = 1'b1;
      end else if (c_req && d_req) begin
`ifdef DM_ARB_ROUND_ROBIN_EN
        if (ptr_q == PRI_DMA) d_gnt = 1'b1;
        else                  c_gnt = 1'b1;
        ptr_d = (ptr_q == PRI_CPU) ? PRI_DMA : PRI_CPU;
`else
        // DMA is forced through once it has lost STARVE_MAX cycles in a row.
        if (starve_cnt_q == STARVE_LIM) d_gnt = 1'b1;
        else                            c_gnt = 1'b1;
`endif
      end
    end
`ifdef DM_ARB_ROUND_ROBIN_EN
    starve_cnt_d = 4'd0;
`else
    ptr_d = PRI_CPU;
    if (!d_req || d_gnt)              starve_cnt_d = 4'd0;
    else if (starve_cnt_q < STARVE_LIM) starve_cnt_d = starve_cnt_q + 4'd1;
`endif
  end

  // Memory-side mux; address and write data hold when idle so the RAM pins stay quiet.
  always_comb begin
    dm_addr_d  = dm_addr_q;
    dm_wdata_d = dm_wdata_q;
    dm_byteen  = 4'b0;
    rd_c_d     = 1'b0;
    rd_d_d     = 1'b0;
    if (c_gnt) begin
      dm_addr_d  = c_addr[13:2];
      dm_wdata_d = c_wdata;
      dm_byteen  = c_we ? c_byteen : 4'b0;
      rd_c_d     = !c_we;
    end else if (d_gnt) begin
      dm_addr_d  = d_addr[13:2];
      dm_wdata_d = d_wdata;
      dm_byteen  = d_we ? d_byteen : 4'b0;
      rd_d_d     = !d_we;
    end
  end

  assign dm_addr  = dm_addr_d;
  assign dm_wdata = dm_wdata_d;

  // Read response is gated by reset so a read caught by a reset edge never returns data.
  assign c_rvalid = rd_c_q & sys_rstn;
  assign d_rvalid = rd_d_q & sys_rstn;
  assign c_rdata  = c_rvalid ? dm_rdata : 32'h0;
  assign d_rdata  = d_rvalid ? dm_rdata : 32'h0;

  always_ff @(posedge clk) begin
    if (!sys_rstn) begin
      ptr_q        <= PRI_CPU;
      starve_cnt_q <= 4'd0;
      rd_c_q       <= 1'b0;
      rd_d_q       <= 1'b0;
      dm_addr_q    <= 12'd0;
      dm_wdata_q   <= 32'd0;
    end else begin
      ptr_q        <= ptr_d;
      starve_cnt_q <= starve_cnt_d;
      rd_c_q       <= rd_c_d;
      rd_d_q       <= rd_d_d;
      dm_addr_q    <= dm_addr_d;
      dm_wdata_q   <= dm_wdata_d;
    end
  end

  // Address bits outside the word index, and state that the selected build does not use.
  logic unused_bits;
`ifdef DM_ARB_ROUND_ROBIN_EN
  assign unused_bits = ^{c_addr[31:14], c_addr[1:0], d_addr[31:14], d_addr[1:0],
                         STARVE_LIM, starve_cnt_q};
`else
  assign unused_bits = ^{c_addr[31:14], c_addr[1:0], d_addr[31:14], d_addr[1:0],
                         ptr_q == PRI_DMA};
`endif

endmodule

// File: tb/tb_dm_arbiter.sv
// Bench for dm_arbiter: directed vectors plus a per-cycle reference model of grant and response.
module tb_dm_arbiter;

  localparam int SMAX = 4;

  logic        clk = 1'b0;
  logic        sys_rstn;
  logic        c_req, c_we, d_req, d_we;
  logic [31:0] c_addr, c_wdata, d_addr, d_wdata;
  logic [3:0]  c_byteen, d_byteen;
  logic        c_gnt, c_rvalid, d_gnt, d_rvalid;
  logic [31:0] c_rdata, d_rdata;
  logic [11:0] dm_addr;
  logic [31:0] dm_wdata, dm_rdata;
  logic [3:0]  dm_byteen;

  int n_cmp = 0;
  int n_bad = 0;

  dm_arbiter #(.STARVE_MAX(SMAX)) dut (
    .clk(clk), .sys_rstn(sys_rstn),
    .c_req(c_req), .c_we(c_we), .c_addr(c_addr), .c_wdata(c_wdata), .c_byteen(c_byteen),
    .c_gnt(c_gnt), .c_rvalid(c_rvalid), .c_rdata(c_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_byteen(d_byteen),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .dm_addr(dm_addr), .dm_wdata(dm_wdata), .dm_byteen(dm_byteen), .dm_rdata(dm_rdata)
  );

  always #5 clk = ~clk;

  // Block-RAM model: byte-enabled write, registered read.
  logic [31:0] mem [4096];
  initial begin
    for (int i = 0; i < 4096; i++) mem[i] = {16'hC0DE, 16'(i)};
    mem[4] = 32'hDEAD_BEEF;
  end
  always @(posedge clk) begin
    for (int b = 0; b < 4; b++)
      if (dm_byteen[b]) mem[dm_addr][8*b +: 8] <= dm_wdata[8*b +: 8];
    dm_rdata <= mem[dm_addr];
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: losses = consecutive cycles the DMA asked and lost; pend = who gets read data.
  int          m_loss = 0, n_loss;
  int          m_pend = 0, n_pend;       // 0 none, 1 cpu, 2 dma
  logic [11:0] m_paddr = 0, n_paddr;
  logic        m_turn = 0, n_turn;       // round-robin: 0 cpu next, 1 dma next
  logic        e_c, e_d, g_we;
  logic [31:0] g_addr, g_wdata;
  logic [3:0]  g_be;

  always @(negedge clk) begin
    e_c = 0; e_d = 0;
    if (sys_rstn === 1'b1) begin
      if (c_req && !d_req) e_c = 1;
      else if (d_req && !c_req) e_d = 1;
      else if (c_req && d_req) begin
`ifdef DM_ARB_ROUND_ROBIN_EN
        if (m_turn) e_d = 1; else e_c = 1;
`else
        if (m_loss >= SMAX) e_d = 1; else e_c = 1;
`endif
      end
    end
    chk("c_gnt", c_gnt, e_c);
    chk("d_gnt", d_gnt, e_d);
    if (e_c || e_d) begin
      g_we = e_c ? c_we : d_we;
      g_addr = e_c ? c_addr : d_addr;
      g_wdata = e_c ? c_wdata : d_wdata;
      g_be = e_c ? c_byteen : d_byteen;
      chk("dm_addr", dm_addr, g_addr / 4 % 4096);
      chk("dm_byteen", dm_byteen, g_we ? g_be : 4'b0);
      if (g_we) chk("dm_wdata", dm_wdata, g_wdata);
    end else begin
      chk("dm_byteen_idle", dm_byteen, 0);
    end
    chk("c_rvalid", c_rvalid, sys_rstn && m_pend == 1);
    chk("d_rvalid", d_rvalid, sys_rstn && m_pend == 2);
    chk("c_rdata", c_rdata, (sys_rstn && m_pend == 1) ? mem[m_paddr] : 32'h0);
    chk("d_rdata", d_rdata, (sys_rstn && m_pend == 2) ? mem[m_paddr] : 32'h0);
    // next-cycle model state
    n_pend = 0; n_paddr = m_paddr; n_loss = 0; n_turn = m_turn;
    if (sys_rstn === 1'b1) begin
      if (e_c && !c_we) begin n_pend = 1; n_paddr = c_addr[13:2]; end
      if (e_d && !d_we) begin n_pend = 2; n_paddr = d_addr[13:2]; end
      if (d_req && !e_d) n_loss = (m_loss + 1 > SMAX) ? SMAX : m_loss + 1;
      if (c_req && d_req) n_turn = ~m_turn;
    end else begin
      n_turn = 0;
    end
  end

  always @(posedge clk) begin
    m_loss = n_loss; m_pend = n_pend; m_paddr = n_paddr; m_turn = n_turn;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    sys_rstn = 0;
    c_req = 1; c_we = 0; c_addr = 0; c_wdata = 0; c_byteen = 4'hF;
    d_req = 0; d_we = 0; d_addr = 0; d_wdata = 0; d_byteen = 0;
    // reset: grants and byte enables forced low while requesting
    @(negedge clk);
    chk("rst_c_gnt", c_gnt, 0);
    chk("rst_byteen", dm_byteen, 0);
    tick();
    @(negedge clk);
    chk("rst_dm_addr", dm_addr, 0);
    chk("rst_c_rvalid", c_rvalid, 0);
    tick();
    sys_rstn = 1; c_req = 0;

    // CPU read of word 4
    c_req = 1; c_we = 0; c_addr = 32'h10;
    @(negedge clk);
    chk("cpu_rd_gnt", c_gnt, 1);
    chk("cpu_rd_addr", dm_addr, 4);
    chk("cpu_rd_be", dm_byteen, 0);
    tick(); c_req = 0;
    @(negedge clk);
    chk("cpu_rd_rvalid", c_rvalid, 1);
    chk("cpu_rd_rdata", c_rdata, 32'hDEAD_BEEF);

    // DMA partial write to word 8
    tick();
    d_req = 1; d_we = 1; d_addr = 32'h20; d_byteen = 4'b0011; d_wdata = 32'h1234_5678;
    @(negedge clk);
    chk("dma_wr_gnt", d_gnt, 1);
    chk("dma_wr_addr", dm_addr, 8);
    chk("dma_wr_be", dm_byteen, 4'b0011);
    tick(); d_req = 0; d_we = 0;
    @(negedge clk);
    chk("dma_wr_no_rvalid", d_rvalid, 0);

    // back-to-back CPU reads of words 1..3
    for (int k = 1; k <= 5; k++) begin
      tick();
      if (k <= 3) begin c_req = 1; c_addr = 32'(k * 4); end
      else c_req = 0;
      @(negedge clk);
      if (k >= 2 && k <= 4) begin
        chk("b2b_rvalid", c_rvalid, 1);
        chk("b2b_rdata", c_rdata, 32'hC0DE_0000 + 32'(k - 1));
      end else if (k == 5) begin
        chk("b2b_end_rvalid", c_rvalid, 0);
      end
    end

    // DMA reads back the partially written word 8
    tick(); d_req = 1; d_addr = 32'h20;
    tick(); d_req = 0;
    @(negedge clk);
    chk("dma_rd_rdata", d_rdata, 32'hC0DE_5678);
    chk("cpu_rdata_zero", c_rdata, 0);

    // contention: CPU wins until DMA has lost SMAX cycles
    tick();
    c_req = 1; c_addr = 0; d_req = 1; d_we = 0; d_addr = 32'h40;
    for (int k = 0; k < 7; k++) begin
      @(negedge clk);
`ifndef DM_ARB_ROUND_ROBIN_EN
      chk("starve_d_gnt", d_gnt, k == 4);
      chk("starve_c_gnt", c_gnt, k != 4);
`else
      chk("rr_d_gnt", d_gnt, k % 2);
`endif
      tick();
    end
    c_req = 0; d_req = 0;
    // dropping d_req clears the loss run
    tick(); c_req = 1; d_req = 1;
    tick(); tick(); d_req = 0;
    tick(); d_req = 1;
    for (int k = 0; k < 5; k++) begin
`ifndef DM_ARB_ROUND_ROBIN_EN
      @(negedge clk);
      chk("clear_d_gnt", d_gnt, k == 4);
`endif
      tick();
    end
    c_req = 0; d_req = 0;

    // reset right after a granted CPU read
    tick();
    c_req = 1; c_addr = 32'h10; d_req = 1; d_addr = 32'h40;
    @(negedge clk);
    chk("mid_rd_gnt", c_gnt, 1);
    tick(); sys_rstn = 0; c_req = 0;
    @(negedge clk);
    chk("mid_rst_rvalid", c_rvalid, 0);
    chk("mid_rst_d_gnt", d_gnt, 0);
    tick();
    @(negedge clk);
    chk("mid_rst_starve", 32'(dut.starve_cnt_q), 0);
    chk("mid_rst_rvalid2", c_rvalid, 0);
    tick(); sys_rstn = 1; d_we = 1; d_addr = 32'h44; d_wdata = 32'hA5A5_A5A5; d_byteen = 4'hF;
    @(negedge clk);
    chk("post_rst_d_gnt", d_gnt, 1);
    tick(); d_req = 0; d_we = 0;
    @(negedge clk);
    chk("post_rst_no_rvalid", d_rvalid, 0);
    tick(); tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/dm_arbiter.md
DM_ARBITER -- requirements
Module: dm_arbiter

Interface
REQ-001 SHALL have parameter STARVE_MAX, default 4, which sets how many consecutive lost cycles a DMA request tolerates before it is forced through (range 1..15).
REQ-002 SHALL have port clk, input, 1 bit: the single system clock; all state changes on its rising edge.
REQ-003 SHALL have port sys_rstn, input, 1 bit: synchronous, active-low reset.
REQ-004 SHALL have CPU port inputs c_req (1), c_we (1), c_addr (32), c_wdata (32) and c_byteen (4): the request, write flag, byte address, write data and write byte enables.
REQ-005 SHALL have CPU port outputs c_gnt (1), c_rvalid (1) and c_rdata (32): grant, read-data valid and read data.
REQ-006 SHALL have DMA port inputs d_req, d_we, d_addr, d_wdata and d_byteen, with the same widths and meanings as the CPU port inputs.
REQ-007 SHALL have DMA port outputs d_gnt, d_rvalid and d_rdata, with the same widths and meanings as the CPU port outputs.
REQ-008 SHALL have DM-side outputs dm_addr (12), dm_wdata (32) and dm_byteen (4): the word address (addr[13:2]), write data and byte write enables.
REQ-009 SHALL have DM-side input dm_rdata (32): the block-RAM read data, valid one cycle after its address is presented.

Function
REQ-010 SHALL grant at most one requester per cycle; c_gnt and d_gnt SHALL be combinational in the same cycle as the request and never both 1.
REQ-011 SHALL require a requester to hold req and all of its fields stable until it sees gnt=1; a transfer completes on the cycle gnt=1.
REQ-012 SHALL drive dm_addr, dm_wdata and dm_byteen from the granted port; with no grant, dm_byteen=0 and dm_addr/dm_wdata hold their previous values.
REQ-013 SHALL force dm_byteen=0 for a granted read (we=0), whatever the requester's byteen.
REQ-014 SHALL register the owner of a granted read and assert that port's rvalid for exactly one cycle, the cycle after the grant, with rdata=dm_rdata; a granted write produces no rvalid.
REQ-015 SHALL hold the non-owner port's rdata at 0 whenever its rvalid is 0.
REQ-016 SHALL support back-to-back grants every cycle, so a read pipelines with the next access and throughput is 1 access/cycle.
REQ-017 SHALL implement arbitration state PRI_CPU / PRI_DMA (the next-priority pointer) and a 4-bit starvation counter starve_cnt.
REQ-018 Default policy (macro absent): SHALL give the CPU fixed priority and increment starve_cnt on each cycle d_req=1 and d_gnt=0.
REQ-019 SHALL, when starve_cnt==STARVE_MAX, grant DMA on that cycle even if c_req=1.
REQ-020 SHALL clear starve_cnt on any d_gnt or whenever d_req=0.
REQ-021 SHALL, when only one port requests, grant it immediately regardless of policy or pointer.
REQ-022 SHALL not wrap starve_cnt: it saturates at STARVE_MAX.

Reset
REQ-023 SHALL treat sys_rstn=0 at a clk edge as reset: pointer=PRI_CPU, starve_cnt=0, read-owner cleared, and c_rvalid=d_rvalid=0 on the next cycle.
REQ-024 SHALL force c_gnt=d_gnt=0 and dm_byteen=0 while sys_rstn=0 and reset dm_addr to 0.
REQ-025 SHALL drop, without an rvalid, a read granted in the cycle reset asserts.
REQ-026 SHALL resume arbitration on the first edge with sys_rstn=1.

Configuration
REQ-027 SHALL, when macro DM_ARB_ROUND_ROBIN_EN is defined, replace REQ-018..REQ-022 with round-robin arbitration: on simultaneous requests, grant the port named by the pointer, then flip the pointer to the other port after every contested grant.
REQ-028 SHALL, with DM_ARB_ROUND_ROBIN_EN defined, tie starve_cnt to 0 and remove its logic; without the macro, the pointer is unused and remains PRI_CPU.

Verification
REQ-029 CPU read: c_req=1, c_we=0, c_addr=0x0000_0010, DM word 4 = 0xDEAD_BEEF -> c_gnt=1 in the same cycle with dm_addr=4 and dm_byteen=0; next cycle c_rvalid=1 and c_rdata=0xDEAD_BEEF.
REQ-030 DMA write: d_req=1, d_we=1, d_addr=0x0000_0020, d_byteen=4'b0011, d_wdata=0x1234_5678 -> d_gnt=1, dm_addr=8, dm_byteen=4'b0011; no rvalid follows.
REQ-031 Starvation (default build, STARVE_MAX=4): c_req and d_req both held at 1 -> c_gnt for 4 cycles, d_gnt on cycle 5, then c_gnt resumes.
REQ-032 Round-robin (DM_ARB_ROUND_ROBIN_EN defined): both ports requesting continuously from reset -> grants alternate C, D, C, D; exactly one gnt per cycle.
REQ-033 Reset mid-read: CPU read granted and sys_rstn=0 on the next edge -> c_rvalid stays 0, all gnt=0 and starve_cnt=0; the first post-reset request is granted normally.
REQ-034 Back-to-back reads: CPU reads words 1, 2 and 3 on consecutive cycles -> c_rvalid high for 3 consecutive cycles with data in order.
